// File: rtl/l2norm_axis_source_pkg.sv
// l2norm_axis_pkg: shared widths, beat record and packer state encoding for
// the L2-norm AXI-Stream source.
//   ELEM_W / BEAT_W : element and output beat widths
//   KEEP_FULL/LO    : tkeep codes for a two-element and a one-element beat
//   axis_beat_t     : one FIFO entry {data, keep, last, user}
//   pack_state_t    : packer FSM states
package l2norm_axis_pkg;

  localparam int ELEM_W = 32;
  localparam int BEAT_W = 64;
  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_LO   = 8'h0F;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [7:0]        keep;
    logic              last;
    logic              user;
  } axis_beat_t;

  typedef enum logic {
    LO_EMPTY = 1'b0,
    LO_HELD  = 1'b1
  } pack_state_t;

  function automatic axis_beat_t make_beat(input logic [ELEM_W-1:0] hi,
                                           input logic [ELEM_W-1:0] lo,
                                           input logic [7:0]        keep,
                                           input logic              last,
                                           input logic              user);
    axis_beat_t b;
    b.data = {hi, lo};
    b.keep = keep;
    b.last = last;
    b.user = user;
    return b;
  endfunction

endpackage

// File: rtl/l2norm_axis_source_if.sv
// l2norm_axis_source_if: element input stream and packed beat output stream.
//   io_in_*  : 32-bit element stream (tdata/tvalid/tlast in, tready out of DUT)
//   io_out_* : 64-bit beat stream (tdata/tvalid/tkeep/tlast/tuser out, tready in)
// modport master : the source block itself (consumes elements, drives beats)
// modport slave  : the environment (drives elements, consumes beats)
interface l2norm_axis_source_if;
  import l2norm_axis_pkg::*;

  logic [ELEM_W-1:0] io_in_tdata;
  logic              io_in_tvalid;
  logic              io_in_tready;
  logic              io_in_tlast;

  logic [BEAT_W-1:0] io_out_tdata;
  logic              io_out_tvalid;
  logic              io_out_tready;
  logic [7:0]        io_out_tkeep;
  logic              io_out_tlast;
  logic              io_out_tuser;

  modport master (
    input  io_in_tdata, io_in_tvalid, io_in_tlast, io_out_tready,
    output io_in_tready, io_out_tdata, io_out_tvalid, io_out_tkeep,
           io_out_tlast, io_out_tuser
  );

  modport slave (
    output io_in_tdata, io_in_tvalid, io_in_tlast, io_out_tready,
    input  io_in_tready, io_out_tdata, io_out_tvalid, io_out_tkeep,
           io_out_tlast, io_out_tuser
  );
endinterface

// File: rtl/l2norm_axis_source_fifo.sv
// axis_beat_fifo: 2-entry FIFO of axis_beat_t.
//   clock, reset  : rising-edge clock, async active-low reset
//   push_i/beat_i : write request and entry
//   pop_i         : consume the head entry
//   head_o        : head entry (all-zero after reset)
//   full_o/empty_o: occupancy flags
// Push and pop in the same cycle are both performed.
module axis_beat_fifo
  import l2norm_axis_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push_i,
  input  axis_beat_t beat_i,
  input  logic       pop_i,
  output axis_beat_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  axis_beat_t mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/l2norm_axis_source.sv
// l2norm_axis_source: packs 32-bit elements pairwise into 64-bit AXI-Stream
// beats for the L2-norm engine, with tkeep/tlast/tuser framing.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : element input and beat output streams (master modport)
//   io_vec_count : vectors whose last beat has been handshaken (wraps)
//
// state    | meaning
// LO_EMPTY | no element held; next element is the low half of a beat
// LO_HELD  | low element waits in lo_q for its high partner
module l2norm_axis_source
  import l2norm_axis_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  l2norm_axis_source_if.master    bus,
  output logic [CNT_W-1:0]        io_vec_count
);

  pack_state_t       state_q, state_d;
  logic [ELEM_W-1:0] lo_q, lo_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;

  logic       in_ready, accept, push, pop;
  axis_beat_t push_beat, head;
  logic       fifo_full, fifo_empty;

  axis_beat_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .beat_i  (push_beat),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready depends only on FIFO occupancy, never on io_out_tready, and is
  // held low while reset is asserted.
  assign in_ready = reset & ~fifo_full;
  assign accept   = bus.io_in_tvalid & in_ready;
  assign pop      = ~fifo_empty & bus.io_out_tready;

  assign bus.io_in_tready  = in_ready;
  assign bus.io_out_tvalid = ~fifo_empty;
  assign bus.io_out_tdata  = head.data;
  assign bus.io_out_tkeep  = head.keep;
  assign bus.io_out_tlast  = head.last;
  assign bus.io_out_tuser  = head.user;
  assign io_vec_count      = vec_cnt_q;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    push      = 1'b0;
    push_beat = '0;
    case (state_q)
      LO_EMPTY: begin
        if (accept) begin
          if (bus.io_in_tlast) begin
            // Lone trailing element: pad the high half, never merge with
            // the next vector.
            push      = 1'b1;
            push_beat = make_beat('0, bus.io_in_tdata, KEEP_LO, 1'b1, first_q);
          end else begin
            lo_d    = bus.io_in_tdata;
            state_d = LO_HELD;
          end
        end
      end
      LO_HELD: begin
        if (accept) begin
          push      = 1'b1;
          push_beat = make_beat(bus.io_in_tdata, lo_q, KEEP_FULL,
                                bus.io_in_tlast, first_q);
          state_d   = LO_EMPTY;
        end
      end
      default: state_d = LO_EMPTY;
    endcase

    // The beat after a last beat opens a new vector.
    first_d = push ? push_beat.last : first_q;

    vec_cnt_d = vec_cnt_q;
    if (pop && head.last) vec_cnt_d = vec_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= LO_EMPTY;
      lo_q      <= '0;
      first_q   <= 1'b1;
      vec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      first_q   <= first_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

endmodule

// File: tb/tb_l2norm_axis_source.sv
module tb_l2norm_axis_source;
  import l2norm_axis_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] vec_count;

  l2norm_axis_source_if bus();

  l2norm_axis_source #(.CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .io_vec_count (vec_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  axis_beat_t exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] hi, input logic [31:0] lo,
                             input logic [7:0] keep, input logic last, input logic user);
    exp_q.push_back(make_beat(hi, lo, keep, last, user));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Inputs change #1 after a rising edge; acceptance is sampled on the
  // falling edge and takes effect on the following rising edge.
  task automatic send(input logic [31:0] data, input logic last);
    bit done;
    done = 1'b0;
    bus.io_in_tvalid = 1'b1;
    bus.io_in_tdata  = data;
    bus.io_in_tlast  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.io_in_tready) begin
        @(posedge clock);
        #1;
        done = 1'b1;
      end
    end
    bus.io_in_tvalid = 1'b0;
    bus.io_in_tlast  = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
    cycles(2);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Output scoreboard.
  always @(negedge clock) begin
    if (reset && bus.io_out_tvalid && bus.io_out_tready) begin
      axis_beat_t got, exp;
      got = make_beat(bus.io_out_tdata[63:32], bus.io_out_tdata[31:0],
                      bus.io_out_tkeep, bus.io_out_tlast, bus.io_out_tuser);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%h expected=none", got);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        checks++;
        assert (got === exp) else begin
          errors++;
          $error("FAIL beat observed=%h expected=%h", got, exp);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_tvalid"}, 64'(bus.io_out_tvalid), 64'd0);
    chk({tag, "_tdata"},  bus.io_out_tdata, 64'd0);
    chk({tag, "_tkeep"},  64'(bus.io_out_tkeep), 64'd0);
    chk({tag, "_tlast"},  64'(bus.io_out_tlast), 64'd0);
    chk({tag, "_tuser"},  64'(bus.io_out_tuser), 64'd0);
    chk({tag, "_in_tready"}, 64'(bus.io_in_tready), 64'd0);
    chk({tag, "_vec_count"}, 64'(vec_count), 64'd0);
  endtask

  initial begin
    bus.io_in_tvalid  = 1'b0;
    bus.io_in_tdata   = '0;
    bus.io_in_tlast   = 1'b0;
    bus.io_out_tready = 1'b1;

    #2;
    check_reset_values("reset");
    #20;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("ready_after_reset", 64'(bus.io_in_tready), 64'd1);
    cycles(1);

    // Four-element vector.
    expect_beat(32'd2, 32'd1, KEEP_FULL, 1'b0, 1'b1);
    expect_beat(32'd4, 32'd3, KEEP_FULL, 1'b1, 1'b0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b1);
    drain();
    chk("vec_count_1", 64'(vec_count), 64'd1);

    // Odd-length vector.
    expect_beat(32'd6, 32'd5, KEEP_FULL, 1'b0, 1'b1);
    expect_beat(32'd0, 32'd7, KEEP_LO,   1'b1, 1'b0);
    send(32'd5, 1'b0);
    send(32'd6, 1'b0);
    send(32'd7, 1'b1);
    drain();
    chk("vec_count_2", 64'(vec_count), 64'd2);

    // Single-element vector; beat visible the cycle after its handshake.
    expect_beat(32'd0, 32'h19, KEEP_LO, 1'b1, 1'b1);
    send(32'h19, 1'b1);
    chk("latency_tvalid", 64'(bus.io_out_tvalid), 64'd1);
    chk("latency_tdata", bus.io_out_tdata, 64'h00000000_00000019);
    drain();
    chk("vec_count_3", 64'(vec_count), 64'd3);

    // Backpressure: FIFO fills after two beats.
    bus.io_out_tready = 1'b0;
    expect_beat(32'd2, 32'd1, KEEP_FULL, 1'b0, 1'b1);
    expect_beat(32'd4, 32'd3, KEEP_FULL, 1'b0, 1'b0);
    expect_beat(32'd6, 32'd5, KEEP_FULL, 1'b1, 1'b0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    chk("bp_ready_after_3", 64'(bus.io_in_tready), 64'd1);
    send(32'd4, 1'b0);
    chk("bp_ready_after_4", 64'(bus.io_in_tready), 64'd0);
    chk("bp_head_data_0", bus.io_out_tdata, 64'h00000002_00000001);
    cycles(3);
    chk("bp_head_valid", 64'(bus.io_out_tvalid), 64'd1);
    chk("bp_head_data_3", bus.io_out_tdata, 64'h00000002_00000001);
    chk("bp_head_keep", 64'(bus.io_out_tkeep), 64'hFF);
    chk("bp_head_user", 64'(bus.io_out_tuser), 64'd1);
    chk("bp_head_last", 64'(bus.io_out_tlast), 64'd0);
    chk("bp_ready_held_low", 64'(bus.io_in_tready), 64'd0);
    bus.io_out_tready = 1'b1;
    send(32'd5, 1'b0);
    send(32'd6, 1'b1);
    drain();
    chk("vec_count_4", 64'(vec_count), 64'd4);

    // Back-to-back vectors of 3 and 2 elements with continuous valid.
    expect_beat(32'd2, 32'd1, KEEP_FULL, 1'b0, 1'b1);
    expect_beat(32'd0, 32'd3, KEEP_LO,   1'b1, 1'b0);
    expect_beat(32'd5, 32'd4, KEEP_FULL, 1'b1, 1'b1);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    send(32'd4, 1'b0);
    send(32'd5, 1'b1);
    drain();
    chk("vec_count_6", 64'(vec_count), 64'd6);

    // Reset with one queued beat and one held element.
    bus.io_out_tready = 1'b0;
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b0);
    send(32'hA3, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("midreset");
    cycles(2);
    reset = 1'b1;
    bus.io_out_tready = 1'b1;
    cycles(3);
    chk("post_reset_no_stale", 64'(bus.io_out_tvalid), 64'd0);
    chk("post_reset_ready", 64'(bus.io_in_tready), 64'd1);
    expect_beat(32'h31, 32'h30, KEEP_FULL, 1'b1, 1'b1);
    send(32'h30, 1'b0);
    send(32'h31, 1'b1);
    drain();
    chk("post_reset_vec_count", 64'(vec_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
